// File: rtl/axis_packetizer_tx.sv
// axis_packetizer_tx: 16-deep byte FIFO feeding a registered AXI-Stream master.
// Frames fixed-length packets of `len` beats, with early end via in_last.
//
// Ports:
//   clk, resetn          clock, async active-low reset
//   in_data/in_valid     producer byte and its valid
//   in_last              force end-of-packet on this byte
//   in_ready             FIFO has room (depends on fill level only)
//   len                  packet length in beats, 1..31 (0 acts as 1)
//   m_data/m_valid       registered stream data and valid
//   m_last/m_ready       final beat of packet, downstream ready
//   busy                 FIFO non-empty or output beat pending
//   pkt_cnt              completed packets, wraps
module axis_packetizer_tx #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    input  logic [4:0]    len,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    output logic          m_last,
    input  logic          m_ready,
    output logic          busy,
    output logic [CW-1:0] pkt_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] PKT_ONE = 1;

    logic [DW:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [4:0]      beat_cnt_q, beat_cnt_d;
    logic [4:0]      len_lat_q, len_lat_d;
    logic [CW-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [DW-1:0]   m_data_q, m_data_d;
    logic            m_valid_q, m_valid_d;
    logic            m_last_q, m_last_d;

    logic            wr_en;
    logic            rd_en;
    logic [DW:0]     entry;
    logic [4:0]      len_in_eff;
    logic [4:0]      len_eff;
    logic            load_last;

    assign in_ready = (count_q != FULL_C);
    assign wr_en    = in_valid && in_ready;
    // Refill the output register whenever it is empty or being consumed.
    assign rd_en    = (count_q != '0) && (!m_valid_q || m_ready);
    assign entry    = mem_q[rd_ptr_q];

    assign len_in_eff = (len == 5'd0) ? 5'd1 : len;
    // First beat of a packet uses the live len; later beats use the latch.
    assign len_eff    = (beat_cnt_q == 5'd0) ? len_in_eff : len_lat_q;
    assign load_last  = entry[DW] || (beat_cnt_q == len_eff - 5'd1);

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign pkt_cnt = pkt_cnt_q;
    assign busy    = (count_q != '0) || m_valid_q;

    // Storage has no reset; contents are only read below the count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {in_last, in_data};
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        beat_cnt_d = beat_cnt_q;
        len_lat_d  = len_lat_q;
        pkt_cnt_d  = pkt_cnt_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (rd_en) begin
            m_data_d  = entry[DW-1:0];
            m_last_d  = load_last;
            m_valid_d = 1'b1;
            if (beat_cnt_q == 5'd0) begin
                len_lat_d = len_in_eff;
            end
            beat_cnt_d = load_last ? 5'd0 : beat_cnt_q + 5'd1;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (m_valid_q && m_ready && m_last_q) begin
            pkt_cnt_d = pkt_cnt_q + PKT_ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            beat_cnt_q <= '0;
            len_lat_q  <= '0;
            pkt_cnt_q  <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            beat_cnt_q <= beat_cnt_d;
            len_lat_q  <= len_lat_d;
            pkt_cnt_q  <= pkt_cnt_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
        end
    end

endmodule

// File: tb/tb_axis_packetizer_tx.sv
// tb_axis_packetizer_tx: directed and random scenarios for axis_packetizer_tx.
// Expected beats come from a packet-framing model fed by accepted bytes.
module tb_axis_packetizer_tx;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [4:0] len;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic       busy;
    logic [7:0] pkt_cnt;

    axis_packetizer_tx #(.DW(8), .DEPTH(16), .CW(8)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .len      (len),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int         obs_t[$];
    int         m_pos  = 0;
    int         m_plen = 1;
    int         exp_pkt = 0;

    // Packet framing: a packet is `len` bytes (0 means 1) unless a byte
    // flagged last ends it sooner. Length is taken when a packet starts.
    task automatic model_push(input logic [7:0] d, input logic l);
        logic lst;
        if (m_pos == 0) m_plen = (len == 5'd0) ? 1 : int'(len);
        lst = l || (m_pos == m_plen - 1);
        exp_q.push_back({lst, d});
        if (lst) begin
            m_pos = 0;
            exp_pkt++;
        end else begin
            m_pos++;
        end
    endtask

    // Called at a falling edge with inputs already driven; advances one cycle.
    task automatic step();
        if (in_valid && in_ready) model_push(in_data, in_last);
        if (m_valid && m_ready) begin
            obs_q.push_back({m_last, m_data});
            obs_t.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(output bit ok);
        in_valid = 1'b0;
        in_last  = 1'b0;
        m_ready  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic check_stream(output int bad);
        int n;
        bad = 0;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("  beats seen %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < n; i++) begin
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("  beat %0d got last=%b data=%h want last=%b data=%h",
                         i, obs_q[i][8], obs_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
            end
        end
        exp_q.delete();
        obs_q.delete();
        obs_t.delete();
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        len      = 5'd4;
        m_ready  = 1'b0;
        #2;
        checks++;
        if ({m_valid, m_last, busy, m_data, pkt_cnt} !== 19'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset v=%b l=%b b=%b d=%h p=%h r=%b want 0/0/0/00/00/1",
                     m_valid, m_last, busy, m_data, pkt_cnt, in_ready);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        int bad;
        int span;
        len = 5'd4;
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            in_last  = 1'b0;
            step();
            if (i == 1) begin
                checks++;
                if (m_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_lat1 m_valid=%b want 0", m_valid);
                end
            end
            if (i == 2) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== 8'd1) begin
                    errors++;
                    $display("FAIL basic_lat2 v=%b d=%h want 1/01", m_valid, m_data);
                end
            end
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_drain busy=%b want 0", busy);
        end
        span = (obs_t.size() == 8) ? obs_t[7] - obs_t[0] : -1;
        checks++;
        if (span !== 7) begin
            errors++;
            $display("FAIL basic_rate span=%0d want 7", span);
        end
        check_stream(bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL basic_stream bad=%0d want 0", bad);
        end
        checks++;
        if (pkt_cnt !== 8'(exp_pkt) || exp_pkt != 2) begin
            errors++;
            $display("FAIL basic_pkt pkt_cnt=%0d want 2", pkt_cnt);
        end
    endtask

    task automatic test_early_last();
        bit ok;
        int bad;
        len = 5'd8;
        m_ready = 1'b1;
        for (int b = 10; b <= 20; b++) begin
            in_valid = 1'b1;
            in_data  = 8'(b);
            in_last  = (b == 12);
            step();
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL early_drain busy=%b want 0", busy);
        end
        checks++;
        if (obs_q.size() != 11 || obs_q[2] !== 9'h10C || obs_q[10] !== 9'h114) begin
            errors++;
            $display("FAIL early_lastpos n=%0d want 11 beats, last on 12 and 20", obs_q.size());
        end
        check_stream(bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL early_stream bad=%0d want 0", bad);
        end
        checks++;
        if (pkt_cnt !== 8'(exp_pkt)) begin
            errors++;
            $display("FAIL early_pkt pkt_cnt=%0d want %0d", pkt_cnt, exp_pkt % 256);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        int acc = 0;
        len = 5'd17;
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(100 + i);
            in_last  = 1'b0;
            if (in_ready) acc++;
            step();
        end
        checks++;
        if (acc !== 17 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full accepted=%0d in_ready=%b want 17/0", acc, in_ready);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'd100) begin
            errors++;
            $display("FAIL bp_hold v=%b d=%0d want 1/100", m_valid, m_data);
        end
        in_valid = 1'b0;
        m_ready  = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_reopen in_ready=%b want 1", in_ready);
        end
        drain(ok);
        check_stream(bad);
        checks++;
        if (!ok || bad !== 0) begin
            errors++;
            $display("FAIL bp_stream ok=%b bad=%0d want 1/0", ok, bad);
        end
        checks++;
        if (pkt_cnt !== 8'(exp_pkt)) begin
            errors++;
            $display("FAIL bp_pkt pkt_cnt=%0d want %0d", pkt_cnt, exp_pkt % 256);
        end
    endtask

    task automatic test_full_simul();
        bit ok;
        int bad;
        len = 5'd17;
        m_ready = 1'b0;
        for (int i = 0; i < 30 && in_ready; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(200 + i);
            in_last  = 1'b0;
            step();
        end
        in_valid = 1'b1;
        in_data  = 8'hEE;
        m_ready  = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL simul_block in_ready=%b want 0", in_ready);
        end
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul_next in_ready=%b want 1", in_ready);
        end
        drain(ok);
        check_stream(bad);
        checks++;
        if (!ok || bad !== 0) begin
            errors++;
            $display("FAIL simul_stream ok=%b bad=%0d want 1/0", ok, bad);
        end
    endtask

    task automatic test_len_change();
        bit ok;
        int bad;
        len = 5'd3;
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) len = 5'd5;
            in_valid = 1'b1;
            in_data  = 8'(i);
            in_last  = 1'b0;
            step();
        end
        drain(ok);
        checks++;
        if (obs_q.size() != 8 || obs_q[2][8] !== 1'b1 || obs_q[7][8] !== 1'b1) begin
            errors++;
            $display("FAIL lenchg_lastpos n=%0d want last on beats 3 and 8", obs_q.size());
        end
        check_stream(bad);
        checks++;
        if (!ok || bad !== 0) begin
            errors++;
            $display("FAIL lenchg_stream ok=%b bad=%0d want 1/0", ok, bad);
        end
        len = 5'd0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(50 + i);
            in_last  = 1'b0;
            step();
        end
        drain(ok);
        check_stream(bad);
        checks++;
        if (!ok || bad !== 0) begin
            errors++;
            $display("FAIL len0_stream ok=%b bad=%0d want 1/0", ok, bad);
        end
        checks++;
        if (pkt_cnt !== 8'(exp_pkt)) begin
            errors++;
            $display("FAIL len0_pkt pkt_cnt=%0d want %0d", pkt_cnt, exp_pkt % 256);
        end
    endtask

    task automatic test_random();
        bit ok;
        int bad;
        int holds = 0;
        logic       pv, pr, pl;
        logic [7:0] pd;
        len = 5'($urandom_range(0, 31));
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom % 4) != 0;
            in_data  = 8'($urandom);
            in_last  = ($urandom % 10) == 0;
            m_ready  = ($urandom % 3) != 0;
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
            pl = m_last;
            step();
            if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) holds++;
        end
        checks++;
        if (holds !== 0) begin
            errors++;
            $display("FAIL rand_axis_hold violations=%0d want 0", holds);
        end
        drain(ok);
        check_stream(bad);
        checks++;
        if (!ok || bad !== 0) begin
            errors++;
            $display("FAIL rand_stream ok=%b bad=%0d want 1/0", ok, bad);
        end
        checks++;
        if (pkt_cnt !== 8'(exp_pkt)) begin
            errors++;
            $display("FAIL rand_pkt pkt_cnt=%0d want %0d", pkt_cnt, exp_pkt % 256);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int bad;
        len = 5'd1;
        m_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            in_last  = 1'b0;
            step();
        end
        drain(ok);
        check_stream(bad);
        checks++;
        if (!ok || bad !== 0) begin
            errors++;
            $display("FAIL wrap_stream ok=%b bad=%0d want 1/0", ok, bad);
        end
        checks++;
        if (pkt_cnt !== 8'(exp_pkt)) begin
            errors++;
            $display("FAIL wrap_pkt pkt_cnt=%0d want %0d", pkt_cnt, exp_pkt % 256);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int bad;
        len = 5'd2;
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(70 + i);
            in_last  = 1'b0;
            step();
        end
        in_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_last, busy, pkt_cnt} !== 11'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset v=%b l=%b b=%b p=%0d r=%b want 0/0/0/0/1",
                     m_valid, m_last, busy, pkt_cnt, in_ready);
        end
        @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        obs_q.delete();
        obs_t.delete();
        m_pos   = 0;
        exp_pkt = 0;
        len     = 5'd2;
        m_ready = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            in_last  = 1'b0;
            step();
        end
        drain(ok);
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== 9'h001 || obs_q[1] !== 9'h102) begin
            errors++;
            $display("FAIL areset_pkt n=%0d want beats 01 then last 02", obs_q.size());
        end
        check_stream(bad);
        checks++;
        if (!ok || bad !== 0 || pkt_cnt !== 8'd1) begin
            errors++;
            $display("FAIL areset_stream ok=%b bad=%0d pkt=%0d want 1/0/1", ok, bad, pkt_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early_last();
        test_backpressure();
        test_full_simul();
        test_len_change();
        test_random();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
